// File: rtl/aes_pkg.sv
// +----------------------------------------------------------------------------+
// | aes_pkg : shared AES-128 types, S-box table, Rcon constants, GF helpers     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    return RCON[round];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MSB offset of state byte (row r, col c) in the row-major 128-bit bus
  function automatic int boff(input int r, input int c);
    return 127 - 8 * (4 * r + c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// +----------------------------------------------------------------------------+
// | aes_sbox : combinational AES forward S-box, 8-bit in / 8-bit out            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  assign out_o = sbox_lookup(in_i);

endmodule

`default_nettype wire

// File: rtl/aes.sv
// +----------------------------------------------------------------------------+
// | aes : iterative AES-128 encryptor, one round per cycle, on-the-fly keys    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] ciphertext,
  output logic         done
);

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] ct_q, ct_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         done_q, done_d;

  logic [127:0] w_sub, w_sr, w_mc, w_nrk, w_rnd;
  logic [31:0]  w_ks;
  logic [7:0]   w_acc;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      aes_sbox u_sbox (
        .in_i  (st_q[boff(r, c) -: 8]),
        .out_o (w_sub[boff(r, c) -: 8])
      );
      assign w_sr[boff(r, c) -: 8] = w_sub[boff(r, (c + r) % 4) -: 8];
    end
    // RotWord folded into the tap: key-schedule row r reads row r+1 of column 3
    aes_sbox u_ks_sbox (
      .in_i  (rk_q[boff((r + 1) % 4, 3) -: 8]),
      .out_o (w_ks[31 - 8 * r -: 8])
    );
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    for (genvar r = 0; r < 4; r++) begin : g_mrow
      assign w_mc[boff(r, c) -: 8] =
          xtime(w_sr[boff(r, c) -: 8])
        ^ xtime(w_sr[boff((r + 1) % 4, c) -: 8]) ^ w_sr[boff((r + 1) % 4, c) -: 8]
        ^ w_sr[boff((r + 2) % 4, c) -: 8]
        ^ w_sr[boff((r + 3) % 4, c) -: 8];
    end
  end

  always_comb begin
    w_nrk = '0;
    w_acc = '0;
    for (int r = 0; r < 4; r++) begin
      w_acc = w_ks[31 - 8 * r -: 8] ^ ((r == 0) ? rcon(cnt_q) : 8'h00);
      for (int c = 0; c < 4; c++) begin
        w_acc = w_acc ^ rk_q[boff(r, c) -: 8];
        w_nrk[boff(r, c) -: 8] = w_acc;
      end
    end
  end

  assign w_rnd = ((cnt_q == 4'd10) ? w_sr : w_mc) ^ w_nrk;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          done_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (!start) begin
          st_d    = plaintext ^ key;
          rk_d    = key;
          cnt_d   = 4'd1;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (start) begin
          state_d = S_LOAD;
        end else begin
          st_d  = w_rnd;
          rk_d  = w_nrk;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd10) begin
            ct_d    = w_rnd;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      ct_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      ct_q    <= ct_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign ciphertext = ct_q;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_aes.sv
// +----------------------------------------------------------------------------+
// | tb_aes : scoreboard bench for aes against a FIPS-197 reference model       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_aes;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         done;

  aes dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plaintext  (plaintext),
    .key        (key),
    .ciphertext (ciphertext),
    .done       (done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_PT  = 128'h328831E0435A3137F6309807A88DA234;
  localparam logic [127:0] FIPS_KEY = 128'h2B28AB097EAEF7CF15D2154F16A6883C;
  localparam logic [127:0] FIPS_CT  = 128'h3902DC1925DC116A8409850B1DFB9732;
  localparam logic [127:0] ZERO_CT  = 128'h66EF88CAE98A4C344B2CFA2BD43B592E;

  typedef struct {
    logic [127:0] ct;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [7:0]   sbt [256];
  logic         prev_done = 1'b0;
  logic [127:0] prev_ct = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box derived from GF(2^8) inverse plus the affine transform
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a [4];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] out;
    for (int c = 0; c < 4; c++)
      w[c] = {k[127 - 8 * c -: 8], k[127 - 8 * (4 + c) -: 8],
              k[127 - 8 * (8 + c) -: 8], k[127 - 8 * (12 + c) -: 8]};
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127 - 8 * (4 * r + c) -: 8] ^ w[c][31 - 8 * r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbt[s[r][(c + r) % 4]];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) a[r] = t[r][c];
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10)
            s[r][c] = gmul(a[r], 8'h02) ^ gmul(a[(r + 1) % 4], 8'h03) ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
          else
            s[r][c] = a[r];
          s[r][c] = s[r][c] ^ w[4 * rnd + c][31 - 8 * r -: 8];
        end
      end
    end
    out = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        out[127 - 8 * (4 * r + c) -: 8] = s[r][c];
    return out;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] filler(input int mode);
    if (mode == 0) return '0;
    if (mode == 1) return '1;
    return rnd128();
  endfunction

  // Start pulse now, data in the LOAD cycle, filler otherwise; done must stay
  // low from the start edge through round 10.  abort_at>0 returns early.
  task automatic start_op(input logic [127:0] pt, input logic [127:0] k,
                          input logic [127:0] exp_ct, input int mode, input int abort_at);
    exp_t e;
    start     = 1'b1;
    plaintext = filler(mode);
    key       = filler(mode);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      chk("done_low", {127'd0, done}, 128'd0);
      if (i == abort_at) return;
      if (i == 0) begin
        start     = 1'b0;
        plaintext = pt;
        key       = k;
        e.ct      = exp_ct;
        e.cyc     = cyc + 11;
        sb.push_back(e);
      end else if (i == 1) begin
        plaintext = filler(mode);
        key       = filler(mode);
      end
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1 && prev_done !== 1'b1) begin
      chk("done_expected", {127'd0, sb.size() != 0}, 128'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("ciphertext", ciphertext, mon_e.ct);
        chk("done_latency", 128'(cyc), 128'(mon_e.cyc));
      end
    end else if (done === 1'b1 && prev_done === 1'b1) begin
      chk("hold_ciphertext", ciphertext, prev_ct);
    end
    prev_done <= done;
    prev_ct   <= ciphertext;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt, k;
    build_sbox();
    rst       = 1'b1;
    start     = 1'b0;
    plaintext = '0;
    key       = '0;
    repeat (3) @(negedge clk);
    chk("reset_done", {127'd0, done}, 128'd0);
    chk("reset_ct", ciphertext, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    start_op(FIPS_PT, FIPS_KEY, FIPS_CT, 0, -1);
    repeat (20) @(negedge clk);
    chk("hold_done", {127'd0, done}, 128'd1);
    chk("hold_ct", ciphertext, FIPS_CT);

    start_op('0, '0, ZERO_CT, 1, -1);

    start_op(FIPS_PT, FIPS_KEY, FIPS_CT, 2, 5);
    void'(sb.pop_back());
    start_op('0, '0, ZERO_CT, 1, -1);

    pt = rnd128();
    k  = rnd128();
    start_op(pt, k, aes_ref(pt, k), 2, 6);
    void'(sb.pop_back());
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_done", {127'd0, done}, 128'd0);
    chk("midrst_ct", ciphertext, 128'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    start_op(FIPS_PT, FIPS_KEY, FIPS_CT, 0, -1);

    for (int n = 0; n < 8; n++) begin
      pt = rnd128();
      k  = rnd128();
      start_op(pt, k, aes_ref(pt, k), 2, -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
